// File: rtl/alphabet_rank_pkg.sv
// alphabet_rank_pkg
//   Shared definitions for the alphabet rank engine:
//     - default sizing (feature width, beats per class, class count, score width)
//     - rank_state_e : engine phases ACCUM -> SCAN -> REPORT
//     - sat_add      : unsigned add clamped to 2**acc_w-1
//   sat_add works on a wide intermediate so one function serves any ACC_W;
//   callers cast the result down to their own score width.
package alphabet_rank_pkg;

    localparam int DEF_DATA_W  = 15;
    localparam int DEF_N_FEAT  = 21;
    localparam int DEF_N_CLASS = 26;
    localparam int DEF_ACC_W   = 20;

    // Wide enough that a + b never wraps for any score width used here.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } rank_state_e;

    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int               acc_w);
        logic [SAT_W-1:0] max_v;
        logic [SAT_W-1:0] sum;
        max_v = (SAT_W'(1) << acc_w) - SAT_W'(1);
        sum   = a + b;
        return (sum > max_v) ? max_v : sum;
    endfunction

endpackage

// File: rtl/score_ram.sv
// score_ram
//   Single-port synchronous RAM holding one accumulated score per class.
//   Write and read share one address; read data is registered (1-cycle latency).
//   Contents are not reset: every entry is rewritten before it is read.
// Ports
//   clk    in   1       clock
//   we     in   1       write enable
//   addr   in   ADDR_W  shared read/write address (must be < DEPTH)
//   wdata  in   WIDTH   write data
//   rdata  out  WIDTH   data at addr, one cycle after addr is presented
module score_ram
    import alphabet_rank_pkg::*;
#(
    parameter int DEPTH  = DEF_N_CLASS,
    parameter int WIDTH  = DEF_ACC_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/alphabet_rank_engine.sv
// alphabet_rank_engine
//   Streams X/Y feature beats, accumulates saturating |X-Y| per class into
//   score_ram, then scans the RAM and reports the lowest-score class.
//   Optional feature macro: TOP2_EN (adds runner-up tracking and the
//   SECOND_IDX / MARGIN ports). Default build leaves it undefined.
// Handshake: a beat transfers on a rising CLK edge where IN_VALID and IN_READY
//   are both high; IN_READY is high only in ACCUM, and IN_VALID outside ACCUM
//   is dropped, never buffered.
// Ports
//   CLK         in   1       clock
//   RST         in   1       synchronous active-high reset
//   IN_VALID    in   1       beat valid
//   IN_READY    out  1       beat accepted this cycle if IN_VALID
//   X, Y        in   DATA_W  measured / template feature (unsigned)
//   BUSY        out  1       high in SCAN and REPORT
//   OUT_VALID   out  1       one-cycle pulse, result fields just updated
//   BEST_IDX    out  IDX_W   lowest-score class
//   BEST_SCORE  out  ACC_W   lowest score
//   SECOND_IDX  out  IDX_W   runner-up class (TOP2_EN)
//   MARGIN      out  ACC_W   runner-up score minus best score (TOP2_EN)
//   DBG_STATE   out  2       current engine phase
module alphabet_rank_engine
    import alphabet_rank_pkg::*;
#(
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int N_FEAT  = DEF_N_FEAT,
    parameter  int N_CLASS = DEF_N_CLASS,
    parameter  int ACC_W   = DEF_ACC_W,
    localparam int IDX_W   = $clog2(N_CLASS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] X,
    input  logic [DATA_W-1:0] Y,
    output logic              BUSY,
    output logic              OUT_VALID,
    output logic [IDX_W-1:0]  BEST_IDX,
    output logic [ACC_W-1:0]  BEST_SCORE,
`ifdef TOP2_EN
    output logic [IDX_W-1:0]  SECOND_IDX,
    output logic [ACC_W-1:0]  MARGIN,
`endif
    output rank_state_e       DBG_STATE
);

    localparam int FEAT_W = $clog2(N_FEAT + 1);
    // Scan step c reads address c and compares data for address c-1; step
    // N_CLASS+1 only hands the finished result to the output registers.
    localparam int SCAN_W = $clog2(N_CLASS + 2);

    rank_state_e         state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [FEAT_W-1:0]   feat_cnt_q, feat_cnt_d;
    logic [IDX_W-1:0]    class_cnt_q, class_cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [ACC_W-1:0]    run_best_q, run_best_d;
    logic [IDX_W-1:0]    run_idx_q, run_idx_d;
    logic [ACC_W-1:0]    best_score_q, best_score_d;
    logic [IDX_W-1:0]    best_idx_q, best_idx_d;
    logic                out_valid_q, out_valid_d;
`ifdef TOP2_EN
    logic [ACC_W-1:0]    run_sec_q, run_sec_d;
    logic [IDX_W-1:0]    run_sec_idx_q, run_sec_idx_d;
    logic [IDX_W-1:0]    second_idx_q, second_idx_d;
    logic [ACC_W-1:0]    margin_q, margin_d;
`endif

    logic                fire;
    logic [DATA_W-1:0]   diff;
    logic [ACC_W-1:0]    acc_sum;
    logic [IDX_W-1:0]    cmp_idx;
    logic                ram_we;
    logic [IDX_W-1:0]    ram_addr;
    logic [ACC_W-1:0]    ram_rdata;

    assign fire    = IN_VALID && in_ready_q && (state_q == ACCUM);
    assign diff    = (X >= Y) ? (X - Y) : (Y - X);
    assign acc_sum = ACC_W'(sat_add(SAT_W'(acc_q), SAT_W'(diff), ACC_W));
    assign cmp_idx = IDX_W'(scan_cnt_q - SCAN_W'(1));

    score_ram #(
        .DEPTH  (N_CLASS),
        .WIDTH  (ACC_W),
        .ADDR_W (IDX_W)
    ) u_score_ram (
        .clk   (CLK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (acc_sum),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        feat_cnt_d   = feat_cnt_q;
        class_cnt_d  = class_cnt_q;
        acc_d        = acc_q;
        scan_cnt_d   = scan_cnt_q;
        run_best_d   = run_best_q;
        run_idx_d    = run_idx_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        out_valid_d  = 1'b0;
`ifdef TOP2_EN
        run_sec_d     = run_sec_q;
        run_sec_idx_d = run_sec_idx_q;
        second_idx_d  = second_idx_q;
        margin_d      = margin_q;
`endif
        ram_we   = 1'b0;
        ram_addr = class_cnt_q;

        case (state_q)
            ACCUM: begin
                if (fire) begin
                    if (feat_cnt_q == FEAT_W'(N_FEAT - 1)) begin
                        // Last beat of the class: store acc+diff, start next class.
                        ram_we     = 1'b1;
                        acc_d      = '0;
                        feat_cnt_d = '0;
                        if (class_cnt_q == IDX_W'(N_CLASS - 1)) begin
                            class_cnt_d = '0;
                            state_d     = SCAN;
                            scan_cnt_d  = '0;
                            run_best_d  = '1;
                            run_idx_d   = '0;
`ifdef TOP2_EN
                            run_sec_d     = '1;
                            run_sec_idx_d = '0;
`endif
                        end else begin
                            class_cnt_d = class_cnt_q + IDX_W'(1);
                        end
                    end else begin
                        acc_d      = acc_sum;
                        feat_cnt_d = feat_cnt_q + FEAT_W'(1);
                    end
                end
            end

            SCAN: begin
                ram_addr   = (scan_cnt_q < SCAN_W'(N_CLASS)) ? IDX_W'(scan_cnt_q) : '0;
                scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                if (scan_cnt_q >= SCAN_W'(1) && scan_cnt_q <= SCAN_W'(N_CLASS)) begin
                    // Strict less-than: on equal scores the earlier index stays.
                    if (ram_rdata < run_best_q) begin
`ifdef TOP2_EN
                        run_sec_d     = run_best_q;
                        run_sec_idx_d = run_idx_q;
`endif
                        run_best_d = ram_rdata;
                        run_idx_d  = cmp_idx;
                    end
`ifdef TOP2_EN
                    else if (ram_rdata < run_sec_q) begin
                        run_sec_d     = ram_rdata;
                        run_sec_idx_d = cmp_idx;
                    end
`endif
                end
                if (scan_cnt_q == SCAN_W'(N_CLASS + 1)) begin
                    state_d      = REPORT;
                    out_valid_d  = 1'b1;
                    best_score_d = run_best_q;
                    best_idx_d   = run_idx_q;
`ifdef TOP2_EN
                    second_idx_d = run_sec_idx_q;
                    margin_d     = run_sec_q - run_best_q;
`endif
                end
            end

            REPORT: begin
                state_d     = ACCUM;
                scan_cnt_d  = '0;
                feat_cnt_d  = '0;
                class_cnt_d = '0;
                acc_d       = '0;
            end

            default: begin
                state_d = ACCUM;
            end
        endcase

        // Registered ready keeps IN_READY low throughout reset.
        in_ready_d = (state_d == ACCUM);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ACCUM;
            in_ready_q   <= 1'b0;
            feat_cnt_q   <= '0;
            class_cnt_q  <= '0;
            acc_q        <= '0;
            scan_cnt_q   <= '0;
            run_best_q   <= '1;
            run_idx_q    <= '0;
            best_score_q <= '1;
            best_idx_q   <= '0;
            out_valid_q  <= 1'b0;
`ifdef TOP2_EN
            run_sec_q     <= '1;
            run_sec_idx_q <= '0;
            second_idx_q  <= '0;
            margin_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            feat_cnt_q   <= feat_cnt_d;
            class_cnt_q  <= class_cnt_d;
            acc_q        <= acc_d;
            scan_cnt_q   <= scan_cnt_d;
            run_best_q   <= run_best_d;
            run_idx_q    <= run_idx_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            out_valid_q  <= out_valid_d;
`ifdef TOP2_EN
            run_sec_q     <= run_sec_d;
            run_sec_idx_q <= run_sec_idx_d;
            second_idx_q  <= second_idx_d;
            margin_q      <= margin_d;
`endif
        end
    end

    assign IN_READY   = in_ready_q;
    assign BUSY       = (state_q != ACCUM);
    assign OUT_VALID  = out_valid_q;
    assign BEST_IDX   = best_idx_q;
    assign BEST_SCORE = best_score_q;
`ifdef TOP2_EN
    assign SECOND_IDX = second_idx_q;
    assign MARGIN     = margin_q;
`endif
    assign DBG_STATE  = state_q;

endmodule
